fir_frame_buffer: RTL and testbench
===================================

# fir_frame_buffer

Ping-pong frame buffer sitting directly downstream of the FIR filter. It collects the serial `fir_d` samples qualified by `fir_valid` into frames of `FRAME_LEN` words and presents each complete frame in parallel to the FFT stage over a valid/ready handshake. Two banks let one frame be drained while the next is filled; samples that arrive while both banks are full are dropped and flagged.

## Interface
Parameters:
- `DATA_W`, 16: sample width; signed two's complement, passed through unmodified.
- `FRAME_LEN`, 16: samples per frame; must be a power of two, at least 2.

Ports (clock and reset first):
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `fir_valid`  in  1: `fir_d` holds a new sample this cycle.
- `fir_d`  in  DATA_W: FIR output sample.
- `frame_ready`  in  1: the FFT stage accepts the presented frame.
- `frame_valid`  out  1: a complete frame is presented on `frame_data`.
- `frame_data`  out  DATA_W*FRAME_LEN: the frame. Slice `[DATA_W*i +: DATA_W]` is sample i, with i=0 the oldest.
- `overflow`  out  1: sticky flag; a sample was dropped since the last reset.

## Operation
- State:
  - `mem[2][FRAME_LEN]`: sample storage.
  - `full[2]`: per-bank full flags.
  - `wr_bank`: bank being filled.
  - `wr_idx`: write index, log2(FRAME_LEN) bits.
  - `rd_bank`: bank being presented.
- Reset: `full`=0, `wr_bank`=0, `rd_bank`=0, `wr_idx`=0, `overflow`=0, all `mem` cleared to 0.
- Write, when `fir_valid`=1 and the write bank is writable:
  - `mem[wr_bank][wr_idx]` <= `fir_d`; `wr_idx` increments.
  - At `wr_idx`=FRAME_LEN-1 the write completes the frame: set `full[wr_bank]`, wrap `wr_idx` to 0, toggle `wr_bank`.
- Writable means `full[wr_bank]`=0, or a release of the same bank happens in the same cycle.
- Drop: `fir_valid`=1 and the write bank is not writable. The sample is discarded, `overflow` <= 1, and `wr_idx`/`wr_bank` are unchanged.
- Present: `frame_valid` = `full[rd_bank]`; `frame_data` = `mem[rd_bank]`.
- Release: `frame_valid` && `frame_ready` clears `full[rd_bank]` and toggles `rd_bank`.
- `frame_ready` while `frame_valid`=0 has no effect.
- Simultaneous release and frame completion (different banks): both take effect in the same cycle.
- Both banks full implies `wr_bank`==`rd_bank`. An incoming sample in the same cycle as a release is accepted into index 0 of the freed bank. No overflow is raised.
- `overflow` clears only on `rst`.
- Reset mid-frame discards the partial frame and any unread frames. No residual `frame_valid` after reset.
- No arithmetic is performed on samples. Sign is preserved bit-exactly.

## Timing
- All outputs are registered or decoded directly from registers. There is no combinational path from `fir_valid`/`fir_d` to any output.
- `frame_valid` rises on the cycle after the edge that captured the FRAME_LEN-th sample (latency 1).
- `frame_valid` and `frame_data` stay stable until the cycle after acceptance.
- After acceptance, `frame_valid` reflects the other bank in the next cycle. With two frames buffered, back-to-back frames can therefore be presented on consecutive cycles.
- Throughput: one sample per cycle is sustained indefinitely if `frame_ready` is asserted at least once per FRAME_LEN cycles.
- `overflow` rises on the cycle after the first dropped sample.

## Structure
- Shared package `fir_frame_buffer_pkg`: `DATA_W`, `FRAME_LEN`, the derived index width `IDX_W` = log2(FRAME_LEN), and the bank-select type.
- Sub-module `frame_bank`: one FRAME_LEN×DATA_W register bank with synchronous clear, write-enable, write index, and a flattened parallel read port. It is instantiated twice.
- The top level holds `wr_idx`, `wr_bank`, `rd_bank`, `full[]`, `overflow`, and the output mux.

## Test plan
- Reset, then 16 `fir_valid` samples 0x0001..0x0010 with `frame_ready`=1 → `frame_valid` is high one cycle after the 16th write; slice 0 = 0x0001, slice 15 = 0x0010; `frame_valid` drops the next cycle; `overflow`=0.
- Negative data 0x8000, 0xFFFF, 0x7FFF at indices 0..2 → same bit patterns in slices 0..2 (sign untouched).
- `frame_ready`=0, 48 continuous samples → frames 1 and 2 are held. Samples 33..48 are dropped and `overflow`=1 from the cycle after sample 33. Raising `frame_ready` then yields frame 1 followed by frame 2 on consecutive cycles, values intact.
- Both banks full; assert `frame_ready` in the same cycle as a new sample 0x1234 → the sample is stored at index 0 of the freed bank and `overflow` stays 0.
- 7 samples, then `rst`, then 16 samples 0x0100.. → the first frame after reset has slice 0 = 0x0100, with no stale data and no early `frame_valid`.
- Gapped `fir_valid` (1 cycle on, 2 off) across 2 frames → frame contents are in order, and `frame_valid` is asserted exactly one cycle after each 16th sample.

Source files
------------

// File: rtl/fir_frame_buffer_pkg.sv
// Shared configuration and types for the FIR-to-FFT ping-pong frame buffer.
package fir_frame_buffer_pkg;

    // Sample width; samples are signed two's complement and passed through untouched.
    localparam int unsigned DATA_W    = 16;
    // Samples per frame; must be a power of two, at least 2.
    localparam int unsigned FRAME_LEN = 16;
    localparam int unsigned IDX_W     = $clog2(FRAME_LEN);
    localparam int unsigned FRAME_W   = DATA_W * FRAME_LEN;

    // Selects one of the two ping-pong banks.
    typedef enum logic {
        Bank0 = 1'b0,
        Bank1 = 1'b1
    } bank_t;

    function automatic bank_t other_bank(bank_t b);
        return (b == Bank0) ? Bank1 : Bank0;
    endfunction

endpackage

// File: rtl/fir_frame_buffer_if.sv
// Sample-in / frame-out bundle between the FIR, the frame buffer and the FFT stage.
interface fir_frame_buffer_if;
    import fir_frame_buffer_pkg::*;

    logic               fir_valid;
    logic [DATA_W-1:0]  fir_d;
    logic               frame_ready;
    logic               frame_valid;
    logic [FRAME_W-1:0] frame_data;
    logic               overflow;

    // Buffer side: consumes samples, produces frames.
    modport slave (
        input  fir_valid,
        input  fir_d,
        input  frame_ready,
        output frame_valid,
        output frame_data,
        output overflow
    );

    // Environment side: produces samples, consumes frames.
    modport master (
        output fir_valid,
        output fir_d,
        output frame_ready,
        input  frame_valid,
        input  frame_data,
        input  overflow
    );

endinterface

// File: rtl/frame_bank.sv
// One FRAME_LEN x DATA_W register bank: synchronous clear, single write port,
// whole contents exposed as one flattened word (slice i = entry i).
module frame_bank
    import fir_frame_buffer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [DATA_W-1:0]  wr_data,
    output logic [FRAME_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [FRAME_LEN];

    // Storage: cleared on reset, one entry written per enabled cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FRAME_LEN; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    // Parallel read port: flatten entries with index 0 in the low slice.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < FRAME_LEN; i++) begin
            rd_data[DATA_W*i +: DATA_W] = mem_q[i];
        end
    end

endmodule

// File: rtl/fir_frame_buffer.sv
// Ping-pong frame buffer: fills one bank from the FIR sample stream while the
// other is presented to the FFT stage; samples arriving with both banks full
// are dropped and latched into a sticky overflow flag.
module fir_frame_buffer
    import fir_frame_buffer_pkg::*;
(
    input logic                clk,
    input logic                rst,
    fir_frame_buffer_if.slave  bus
);

    logic [1:0]       full_q, full_d;
    bank_t            wr_bank_q, wr_bank_d;
    bank_t            rd_bank_q, rd_bank_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic             overflow_q, overflow_d;

    logic             release_frame;
    logic             writable;
    logic             do_write;
    logic             drop;
    logic             last_idx;
    logic [1:0]       bank_we;
    logic [FRAME_W-1:0] rd_data0, rd_data1;

    // Handshake decode; a release of the write bank frees it for this very sample.
    always_comb begin
        release_frame = full_q[rd_bank_q] && bus.frame_ready;
        writable      = !full_q[wr_bank_q] || (release_frame && (rd_bank_q == wr_bank_q));
        do_write      = bus.fir_valid && writable;
        drop          = bus.fir_valid && !writable;
        last_idx      = (wr_idx_q == IDX_W'(FRAME_LEN - 1));
        bank_we[0]    = do_write && (wr_bank_q == Bank0);
        bank_we[1]    = do_write && (wr_bank_q == Bank1);
    end

    // Next state: release and frame completion may hit different banks in one cycle.
    always_comb begin
        full_d     = full_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        wr_idx_d   = wr_idx_q;
        overflow_d = overflow_q | drop;
        if (release_frame) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = other_bank(rd_bank_q);
        end
        if (do_write) begin
            if (last_idx) begin
                full_d[wr_bank_q] = 1'b1;
                wr_idx_d          = '0;
                wr_bank_d         = other_bank(wr_bank_q);
            end else begin
                wr_idx_d = wr_idx_q + 1'b1;
            end
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q     <= '0;
            wr_bank_q  <= Bank0;
            rd_bank_q  <= Bank0;
            wr_idx_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            full_q     <= full_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            wr_idx_q   <= wr_idx_d;
            overflow_q <= overflow_d;
        end
    end

    frame_bank u_bank0 (
        .clk     (clk),
        .rst     (rst),
        .we      (bank_we[0]),
        .wr_idx  (wr_idx_q),
        .wr_data (bus.fir_d),
        .rd_data (rd_data0)
    );

    frame_bank u_bank1 (
        .clk     (clk),
        .rst     (rst),
        .we      (bank_we[1]),
        .wr_idx  (wr_idx_q),
        .wr_data (bus.fir_d),
        .rd_data (rd_data1)
    );

    // Outputs come straight from registers; no path from the sample inputs.
    assign bus.frame_valid = full_q[rd_bank_q];
    assign bus.frame_data  = (rd_bank_q == Bank1) ? rd_data1 : rd_data0;
    assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_fir_frame_buffer.sv
// Scoreboard bench for fir_frame_buffer: a frame-level reference model predicts
// per-cycle frame_valid/overflow and the sequence of completed frames; a separate
// monitor compares those against the DUT whenever it presents or hands off a frame.
module tb_fir_frame_buffer;
    import fir_frame_buffer_pkg::*;

    typedef logic [FRAME_W-1:0] frame_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fir_frame_buffer_if bus ();

    fir_frame_buffer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Scoreboard queues: expected frames in hand-off order, expected {valid, overflow} per cycle.
    frame_t     frame_q[$];
    logic [1:0] cyc_q[$];

    // Reference model: complete frames waiting for the FFT, plus the frame being collected.
    frame_t      held[$];
    frame_t      part;
    int unsigned part_n;
    logic        m_ov;
    bit          chk_clear;

    task automatic model_reset();
        held.delete();
        frame_q.delete();
        part   = '0;
        part_n = 0;
        m_ov   = 1'b0;
    endtask

    // Two frames of storage; a hand-off in the same cycle frees room for the sample.
    task automatic model_step(bit v, logic [DATA_W-1:0] d, bit r);
        if (r && held.size() > 0) void'(held.pop_front());
        if (v) begin
            if (held.size() < 2) begin
                part[DATA_W*part_n +: DATA_W] = d;
                part_n++;
                if (part_n == FRAME_LEN) begin
                    held.push_back(part);
                    frame_q.push_back(part);
                    part   = '0;
                    part_n = 0;
                end
            end else begin
                m_ov = 1'b1;
            end
        end
    endtask

    // One clock: record what the DUT should show now, then drive inputs for the next edge.
    task automatic cycle(bit r_st, bit v, logic [DATA_W-1:0] d, bit r);
        @(posedge clk);
        #1;
        if (chk_clear) begin
            total++;
            if (bus.frame_data !== '0) begin
                bad++;
                $display("FAIL reset_data got=%h want=0", bus.frame_data);
            end
            chk_clear = 1'b0;
        end
        cyc_q.push_back({held.size() > 0, m_ov});
        rst             = r_st;
        bus.fir_valid   = v;
        bus.fir_d       = d;
        bus.frame_ready = r;
        if (r_st) begin
            model_reset();
            chk_clear = 1'b1;
        end else begin
            model_step(v, d, r);
        end
    endtask

    // Monitor: mid-cycle sampling of the DUT against the scoreboard.
    initial begin
        logic [1:0] e;
        frame_t     exp_f;
        forever begin
            @(negedge clk);
            if (cyc_q.size() > 0) begin
                e = cyc_q.pop_front();
                total++;
                if (bus.frame_valid !== e[1]) begin
                    bad++;
                    $display("FAIL frame_valid @%0t got=%b want=%b", $time, bus.frame_valid, e[1]);
                end
                total++;
                if (bus.overflow !== e[0]) begin
                    bad++;
                    $display("FAIL overflow @%0t got=%b want=%b", $time, bus.overflow, e[0]);
                end
                if (bus.frame_valid === 1'b1 && bus.frame_ready === 1'b1) begin
                    total++;
                    if (frame_q.size() == 0) begin
                        bad++;
                        $display("FAIL frame_unexpected @%0t got=%h want=none", $time,
                                 bus.frame_data);
                    end else begin
                        exp_f = frame_q.pop_front();
                        if (bus.frame_data !== exp_f) begin
                            bad++;
                            $display("FAIL frame_data @%0t got=%h want=%h", $time,
                                     bus.frame_data, exp_f);
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic [DATA_W-1:0] val;
        rst             = 1'b1;
        bus.fir_valid   = 1'b0;
        bus.fir_d       = '0;
        bus.frame_ready = 1'b0;
        chk_clear       = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        cycle(1, 0, '0, 0);

        // Single frame 0x0001..0x0010 with the FFT always ready.
        for (int i = 1; i <= 16; i++) cycle(0, 1, DATA_W'(i), 1);
        repeat (3) cycle(0, 0, '0, 1);

        // Sign patterns pass through bit-exactly.
        for (int i = 0; i < 16; i++) begin
            val = (i == 0) ? 16'h8000 : (i == 1) ? 16'hFFFF : (i == 2) ? 16'h7FFF : DATA_W'(i);
            cycle(0, 1, val, 1);
        end
        repeat (3) cycle(0, 0, '0, 1);

        // Both banks fill, third frame dropped, then back-to-back hand-off.
        for (int i = 1; i <= 48; i++) cycle(0, 1, DATA_W'(i), 0);
        repeat (4) cycle(0, 0, '0, 1);

        // Release of the full write bank coincides with a new sample: no drop.
        cycle(1, 0, '0, 0);
        for (int i = 0; i < 32; i++) cycle(0, 1, DATA_W'(16'h2000 + i), 0);
        cycle(0, 1, 16'h1234, 1);
        for (int i = 1; i < 16; i++) cycle(0, 1, DATA_W'(16'h3000 + i), 1);
        repeat (4) cycle(0, 0, '0, 1);

        // Partial frame discarded by reset.
        cycle(1, 0, '0, 0);
        for (int i = 0; i < 7; i++) cycle(0, 1, DATA_W'(16'h0700 + i), 0);
        cycle(1, 0, '0, 0);
        for (int i = 0; i < 16; i++) cycle(0, 1, DATA_W'(16'h0100 + i), 0);
        repeat (2) cycle(0, 0, '0, 0);
        repeat (3) cycle(0, 0, '0, 1);

        // Gapped input: one sample then two idle cycles.
        for (int i = 0; i < 32; i++) begin
            cycle(0, 1, DATA_W'(16'h0500 + i), 1);
            repeat (2) cycle(0, 0, '0, 1);
        end

        // Random traffic with sporadic back-pressure and the odd reset.
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 299) == 0) cycle(1, 0, '0, 0);
            else cycle(0, ($urandom_range(0, 3) != 0), DATA_W'($urandom),
                       ($urandom_range(0, 11) == 0));
        end
        repeat (40) cycle(0, 0, '0, 1);

        @(negedge clk);
        #1;
        total++;
        if (frame_q.size() != 0 || cyc_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d frames/%0d cycles pending want=0/0",
                     frame_q.size(), cyc_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
